// File: rtl/instruction_sequencer.sv
// Multicycle control FSM for the ARM-subset datapath: fetch, condition check, execute, memory,
// with a shared request/ready memory port and a retired-instruction counter.
module instruction_sequencer #(
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              instruction,
    input  logic [3:0]               alu_flags,
    input  logic                     memory_ready,
    output logic                     memory_request,
    output logic                     memory_write,
    output logic                     address_source,
    output logic                     instruction_enable,
    output logic                     program_counter_write,
    output logic                     program_counter_source,
    output logic [1:0]               register_source,
    output logic                     register_write,
    output logic [1:0]               immediate_source,
    output logic                     alu_source,
    output logic [1:0]               alu_control,
    output logic                     memory_to_register_file,
    output logic                     instruction_done,
    output logic [COUNTER_WIDTH-1:0] retired_count
);

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned FLAG_WIDTH  = 4;

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] DECODE  = 2'd1;
    localparam logic [1:0] EXECUTE = 2'd2;
    localparam logic [1:0] MEMORY  = 2'd3;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [INSTR_WIDTH-1:0] ir;
    logic [FLAG_WIDTH-1:0]  flags;
    logic                   flags_write;

    logic [3:0] cond;
    logic [1:0] op;
    logic       imm_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       rd_is_pc;
    logic       unused_ir_bits;

    assign cond           = ir[31:28];
    assign op             = ir[27:26];
    assign imm_bit        = ir[25];
    assign cmd            = ir[24:21];
    assign s_bit          = ir[20];
    assign rd_is_pc       = (ir[15:12] == 4'hF);
    assign unused_ir_bits = ^{ir[19:16], ir[11:0]};

    // ARM condition codes against the stored {N,Z,C,V}; 1111 never executes
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = cy;
            4'b0011: cond_pass = !cy;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = cy && !z;
            4'b1001: cond_pass = !cy || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // data-processing command decode: writing commands and ALU operation
    logic       dp_write;
    logic       dp_cmp;
    logic [1:0] dp_alu;

    always_comb begin
        dp_write = 1'b0;
        dp_cmp   = 1'b0;
        dp_alu   = 2'b00;
        case (cmd)
            4'b0100: begin dp_write = 1'b1; dp_alu = 2'b00; end
            4'b0010: begin dp_write = 1'b1; dp_alu = 2'b01; end
            4'b0000: begin dp_write = 1'b1; dp_alu = 2'b10; end
            4'b1100: begin dp_write = 1'b1; dp_alu = 2'b11; end
            4'b1010: begin dp_cmp   = 1'b1; dp_alu = 2'b01; end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // next state and control outputs; everything forced low while reset is asserted
    always_comb begin
        state_next              = state;
        memory_request          = 1'b0;
        memory_write            = 1'b0;
        address_source          = 1'b0;
        instruction_enable      = 1'b0;
        program_counter_write   = 1'b0;
        program_counter_source  = 1'b0;
        register_source         = 2'b00;
        register_write          = 1'b0;
        immediate_source        = 2'b00;
        alu_source              = 1'b0;
        alu_control             = 2'b00;
        memory_to_register_file = 1'b0;
        instruction_done        = 1'b0;
        flags_write             = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    memory_request = 1'b1;
                    if (memory_ready) begin
                        instruction_enable    = 1'b1;
                        program_counter_write = 1'b1;
                        state_next            = DECODE;
                    end
                end
                DECODE: begin
                    case (op)
                        2'b01: begin register_source = 2'b10; immediate_source = 2'b01; end
                        2'b10: begin register_source = 2'b01; immediate_source = 2'b10; end
                        default: ;
                    endcase
                    if (cond_pass(cond, flags)) begin
                        state_next = EXECUTE;
                    end else begin
                        instruction_done = 1'b1;
                        state_next       = FETCH;
                    end
                end
                EXECUTE: begin
                    case (op)
                        2'b00: begin
                            alu_source       = imm_bit;
                            alu_control      = dp_alu;
                            register_write   = dp_write;
                            flags_write      = dp_cmp || (s_bit && dp_write);
                            if (dp_write && rd_is_pc) begin
                                program_counter_write  = 1'b1;
                                program_counter_source = 1'b1;
                            end
                            instruction_done = 1'b1;
                            state_next       = FETCH;
                        end
                        2'b01: begin
                            alu_source       = 1'b1;
                            immediate_source = 2'b01;
                            register_source  = 2'b10;
                            state_next       = MEMORY;
                        end
                        2'b10: begin
                            register_source        = 2'b01;
                            immediate_source       = 2'b10;
                            alu_source             = 1'b1;
                            program_counter_write  = 1'b1;
                            program_counter_source = 1'b1;
                            instruction_done       = 1'b1;
                            state_next             = FETCH;
                        end
                        default: begin
                            instruction_done = 1'b1;
                            state_next       = FETCH;
                        end
                    endcase
                end
                MEMORY: begin
                    memory_request   = 1'b1;
                    address_source   = 1'b1;
                    memory_write     = !s_bit;
                    alu_source       = 1'b1;
                    immediate_source = 2'b01;
                    register_source  = 2'b10;
                    if (memory_ready) begin
                        register_write          = s_bit;
                        memory_to_register_file = s_bit;
                        instruction_done        = 1'b1;
                        state_next              = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    // instruction register, flags register and retired counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir            <= '0;
            flags         <= '0;
            retired_count <= '0;
        end else begin
            if (instruction_enable) begin
                ir <= instruction;
            end
            if (flags_write) begin
                flags <= alu_flags;
            end
            if (instruction_done) begin
                retired_count <= retired_count + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: each task walks one instruction scenario cycle by cycle.
module tb_instruction_sequencer;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [3:0]  alu_flags;
    logic        memory_ready;

    logic        memory_request, memory_write, address_source, instruction_enable;
    logic        program_counter_write, program_counter_source, register_write;
    logic [1:0]  register_source, immediate_source, alu_control;
    logic        alu_source, memory_to_register_file, instruction_done;
    logic [31:0] retired_count;

    logic        w_memory_request, w_memory_write, w_address_source, w_instruction_enable;
    logic        w_program_counter_write, w_program_counter_source, w_register_write;
    logic [1:0]  w_register_source, w_immediate_source, w_alu_control;
    logic        w_alu_source, w_memory_to_register_file, w_instruction_done;
    logic [3:0]  w_retired_count;

    int          checks;
    int          passes;
    int          exp_count;
    logic [15:0] ctl;
    logic [15:0] exp;

    instruction_sequencer dut (
        .clock(clock), .reset(reset), .instruction(instruction), .alu_flags(alu_flags),
        .memory_ready(memory_ready), .memory_request(memory_request), .memory_write(memory_write),
        .address_source(address_source), .instruction_enable(instruction_enable),
        .program_counter_write(program_counter_write), .program_counter_source(program_counter_source),
        .register_source(register_source), .register_write(register_write),
        .immediate_source(immediate_source), .alu_source(alu_source), .alu_control(alu_control),
        .memory_to_register_file(memory_to_register_file), .instruction_done(instruction_done),
        .retired_count(retired_count)
    );

    instruction_sequencer #(.COUNTER_WIDTH(4)) dut_w4 (
        .clock(clock), .reset(reset), .instruction(instruction), .alu_flags(alu_flags),
        .memory_ready(memory_ready), .memory_request(w_memory_request), .memory_write(w_memory_write),
        .address_source(w_address_source), .instruction_enable(w_instruction_enable),
        .program_counter_write(w_program_counter_write), .program_counter_source(w_program_counter_source),
        .register_source(w_register_source), .register_write(w_register_write),
        .immediate_source(w_immediate_source), .alu_source(w_alu_source), .alu_control(w_alu_control),
        .memory_to_register_file(w_memory_to_register_file), .instruction_done(w_instruction_done),
        .retired_count(w_retired_count)
    );

    assign ctl = {memory_request, memory_write, address_source, instruction_enable,
                  program_counter_write, program_counter_source, register_source, register_write,
                  immediate_source, alu_source, alu_control, memory_to_register_file, instruction_done};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] pack(input logic req, input logic mw, input logic as, input logic ie,
                                         input logic pcw, input logic pcs, input logic [1:0] rs,
                                         input logic rw, input logic [1:0] is, input logic als,
                                         input logic [1:0] ac, input logic m2r, input logic done);
        pack = {req, mw, as, ie, pcw, pcs, rs, rw, is, als, ac, m2r, done};
    endfunction

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // one fetch cycle with memory ready, no checking
    task automatic fetch(input logic [31:0] instr);
        instruction  = instr;
        memory_ready = 1'b1;
        #1;
        next();
    endtask

    task automatic test_reset();
        memory_ready = 1'b1;
        instruction  = 32'hE282_1005;
        repeat (2) @(posedge clock);
        #1;
        checks++; exp = '0; if (ctl !== exp) $display("FAIL reset_outputs ctl=%b exp=%b", ctl, exp); else passes++;
        checks++; if ({w_retired_count, retired_count} !== 36'd0) $display("FAIL reset_count got %0d/%0d exp 0", retired_count, w_retired_count); else passes++;
        @(negedge clock);
        reset        = 1'b1;
        memory_ready = 1'b0;
        #1;
        checks++; exp = pack(1,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,0); if (ctl !== exp) $display("FAIL fetch_wait ctl=%b exp=%b", ctl, exp); else passes++;
        next();
    endtask

    task automatic test_add();
        instruction  = 32'hE282_1005;
        memory_ready = 1'b1;
        #1;
        checks++; exp = pack(1,0,0,1,1,0,2'b00,0,2'b00,0,2'b00,0,0); if (ctl !== exp) $display("FAIL add_fetch ctl=%b exp=%b", ctl, exp); else passes++;
        next(); #1;
        checks++; exp = '0; if (ctl !== exp) $display("FAIL add_decode ctl=%b exp=%b", ctl, exp); else passes++;
        next(); #1;
        checks++; exp = pack(0,0,0,0,0,0,2'b00,1,2'b00,1,2'b00,0,1); if (ctl !== exp) $display("FAIL add_execute ctl=%b exp=%b", ctl, exp); else passes++;
        next(); exp_count++;
        checks++; if (retired_count !== 32'(exp_count)) $display("FAIL add_count got %0d exp %0d", retired_count, exp_count); else passes++;
        fetch(32'hE282_F005);
        next(); #1;
        checks++; exp = pack(0,0,0,0,1,1,2'b00,1,2'b00,1,2'b00,0,1); if (ctl !== exp) $display("FAIL add_pc_execute ctl=%b exp=%b", ctl, exp); else passes++;
        next(); exp_count++;
    endtask

    task automatic test_cond_skip();
        fetch(32'hE351_0005);
        next();
        alu_flags = 4'b0100;
        #1;
        checks++; exp = pack(0,0,0,0,0,0,2'b00,0,2'b00,1,2'b01,0,1); if (ctl !== exp) $display("FAIL cmp_execute ctl=%b exp=%b", ctl, exp); else passes++;
        next(); exp_count++;
        alu_flags = 4'b0000;
        fetch(32'h1282_1005);
        #1;
        checks++; exp = pack(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,1); if (ctl !== exp) $display("FAIL addne_decode ctl=%b exp=%b", ctl, exp); else passes++;
        next(); exp_count++;
        memory_ready = 1'b0;
        #1;
        checks++; exp = pack(1,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,0); if (ctl !== exp) $display("FAIL addne_refetch ctl=%b exp=%b", ctl, exp); else passes++;
        checks++; if (retired_count !== 32'(exp_count)) $display("FAIL skip_count got %0d exp %0d", retired_count, exp_count); else passes++;
        fetch(32'h0282_1005);
        #1;
        checks++; exp = '0; if (ctl !== exp) $display("FAIL addeq_decode ctl=%b exp=%b", ctl, exp); else passes++;
        next(); #1;
        checks++; exp = pack(0,0,0,0,0,0,2'b00,1,2'b00,1,2'b00,0,1); if (ctl !== exp) $display("FAIL addeq_execute ctl=%b exp=%b", ctl, exp); else passes++;
        next(); exp_count++;
        fetch(32'hF282_1005);
        #1;
        checks++; exp = pack(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,1); if (ctl !== exp) $display("FAIL never_decode ctl=%b exp=%b", ctl, exp); else passes++;
        next(); exp_count++;
    endtask

    task automatic test_ldr_wait();
        fetch(32'hE591_3004);
        #1;
        checks++; exp = pack(0,0,0,0,0,0,2'b10,0,2'b01,0,2'b00,0,0); if (ctl !== exp) $display("FAIL ldr_decode ctl=%b exp=%b", ctl, exp); else passes++;
        next(); #1;
        checks++; exp = pack(0,0,0,0,0,0,2'b10,0,2'b01,1,2'b00,0,0); if (ctl !== exp) $display("FAIL ldr_execute ctl=%b exp=%b", ctl, exp); else passes++;
        next();
        for (int i = 0; i < 3; i++) begin
            memory_ready = 1'b0;
            #1;
            checks++; exp = pack(1,0,1,0,0,0,2'b10,0,2'b01,1,2'b00,0,0); if (ctl !== exp) $display("FAIL ldr_mem_wait%0d ctl=%b exp=%b", i, ctl, exp); else passes++;
            next();
        end
        memory_ready = 1'b1;
        #1;
        checks++; exp = pack(1,0,1,0,0,0,2'b10,1,2'b01,1,2'b00,1,1); if (ctl !== exp) $display("FAIL ldr_mem_ready ctl=%b exp=%b", ctl, exp); else passes++;
        next(); exp_count++;
        checks++; if (retired_count !== 32'(exp_count)) $display("FAIL ldr_count got %0d exp %0d", retired_count, exp_count); else passes++;
    endtask

    task automatic test_str_wait();
        fetch(32'hE581_3004);
        next(); #1;
        checks++; exp = pack(0,0,0,0,0,0,2'b10,0,2'b01,1,2'b00,0,0); if (ctl !== exp) $display("FAIL str_execute ctl=%b exp=%b", ctl, exp); else passes++;
        next();
        for (int i = 0; i < 2; i++) begin
            memory_ready = 1'b0;
            #1;
            checks++; exp = pack(1,1,1,0,0,0,2'b10,0,2'b01,1,2'b00,0,0); if (ctl !== exp) $display("FAIL str_mem_wait%0d ctl=%b exp=%b", i, ctl, exp); else passes++;
            next();
        end
        memory_ready = 1'b1;
        #1;
        checks++; exp = pack(1,1,1,0,0,0,2'b10,0,2'b01,1,2'b00,0,1); if (ctl !== exp) $display("FAIL str_mem_ready ctl=%b exp=%b", ctl, exp); else passes++;
        next(); exp_count++;
    endtask

    task automatic test_branch();
        fetch(32'hEA00_0002);
        #1;
        checks++; exp = pack(0,0,0,0,0,0,2'b01,0,2'b10,0,2'b00,0,0); if (ctl !== exp) $display("FAIL b_decode ctl=%b exp=%b", ctl, exp); else passes++;
        next(); #1;
        checks++; exp = pack(0,0,0,0,1,1,2'b01,0,2'b10,1,2'b00,0,1); if (ctl !== exp) $display("FAIL b_execute ctl=%b exp=%b", ctl, exp); else passes++;
        next(); exp_count++;
        checks++; if (retired_count !== 32'(exp_count)) $display("FAIL b_count got %0d exp %0d", retired_count, exp_count); else passes++;
    endtask

    task automatic test_reset_mid_memory();
        fetch(32'hE591_3004);
        next();
        next();
        memory_ready = 1'b0;
        #1;
        checks++; if (memory_request !== 1'b1) $display("FAIL mid_mem_request got %b exp 1", memory_request); else passes++;
        reset = 1'b0;
        #1;
        checks++; exp = '0; if (ctl !== exp) $display("FAIL mid_mem_reset ctl=%b exp=%b", ctl, exp); else passes++;
        checks++; if ({w_retired_count, retired_count} !== 36'd0) $display("FAIL mid_mem_count got %0d/%0d exp 0", retired_count, w_retired_count); else passes++;
        exp_count = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; exp = pack(1,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,0); if (ctl !== exp) $display("FAIL mid_mem_refetch ctl=%b exp=%b", ctl, exp); else passes++;
        next();
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 15; i++) begin
            fetch(32'hF282_1005);
            next(); exp_count++;
        end
        checks++; if (w_retired_count !== 4'd15) $display("FAIL wrap_at_15 got %0d exp 15", w_retired_count); else passes++;
        fetch(32'hF282_1005);
        next(); exp_count++;
        checks++; if (w_retired_count !== 4'(exp_count)) $display("FAIL wrap_to_0 got %0d exp %0d", w_retired_count, 4'(exp_count)); else passes++;
        checks++; if (retired_count !== 32'(exp_count)) $display("FAIL wide_count got %0d exp %0d", retired_count, exp_count); else passes++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks       = 0;
        passes       = 0;
        exp_count    = 0;
        reset        = 1'b0;
        instruction  = '0;
        alu_flags    = '0;
        memory_ready = 1'b0;
        test_reset();
        test_add();
        test_cond_skip();
        test_ldr_wait();
        test_str_wait();
        test_branch();
        test_reset_mid_memory();
        test_counter_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
